// File: rtl/cpu_memory.sv
// Memory stage: drives loads and stores over a single-master ready-handshake bus and passes other ops through to writeback.
// Defining CPU_MEMORY_MISALIGNED_EN splits misaligned accesses into two bus cycles. Without it they raise a sticky fault.
module cpu_memory (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic [3:0]  i_tag,
    input  logic [4:0]  i_inst_rd,
    input  logic [31:0] i_rd,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_mem_width,
    input  logic        i_mem_signed,
    input  logic [31:0] i_mem_address,
    output logic [3:0]  o_tag,
    output logic [4:0]  o_inst_rd,
    output logic [31:0] o_rd,
    output logic        o_stall,
    output logic        o_fault,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LO     = 2'd1,
        ST_HI     = 2'd2,
        ST_RETIRE = 2'd3
    } state_t;

    state_t      state_r;
    logic [1:0]  offset_r;
    logic [2:0]  width_r;
    logic        signed_r;
    logic        write_r;
    logic        split_r;
    logic [3:0]  hold_tag_r;
    logic [4:0]  hold_inst_rd_r;
    logic [31:0] hold_rd_r;
    logic [31:0] lo_rdata_r;
    logic [31:0] wdata_hi_r;
    logic [3:0]  wmask_hi_r;

    logic [2:0]  width_s;
    logic        misaligned_s;
    logic        is_mem_s;
    logic        accept_s;
    logic [63:0] store_lanes_s;
    logic [7:0]  mask_lanes_s;
    logic [63:0] load_pair_s;
    logic [31:0] load_value_s;

    function automatic logic [63:0] store_lanes(input logic [31:0] data, input logic [1:0] off);
        return {32'h0000_0000, data} << {off, 3'b000};
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] width, input logic [1:0] off);
        logic [3:0] m;
        case (width)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return {4'b0000, m} << off;
    endfunction

    function automatic logic [31:0] load_extract(input logic [63:0] pair, input logic [1:0] off,
                                                 input logic [2:0] width, input logic sgn);
        logic [63:0] v;
        logic [31:0] r;
        v = pair >> {off, 3'b000};
        case (width)
            3'd1:    r = sgn ? {{24{v[7]}}, v[7:0]} : {24'h00_0000, v[7:0]};
            3'd2:    r = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0000, v[15:0]};
            default: r = v[31:0];
        endcase
        return r;
    endfunction

    // Decode the incoming access: normalised width, alignment and lane placement.
    always_comb begin
        width_s = 3'd4;
        case (i_mem_width)
            3'd1:    width_s = 3'd1;
            3'd2:    width_s = 3'd2;
            default: width_s = 3'd4;
        endcase
        misaligned_s  = ((width_s == 3'd4) && (i_mem_address[1:0] != 2'd0)) ||
                        ((width_s == 3'd2) && (i_mem_address[1:0] == 2'd3));
        is_mem_s      = i_mem_read || i_mem_write;
        accept_s      = (state_r == ST_IDLE) && !i_stall && (i_tag != o_tag);
        store_lanes_s = store_lanes(i_rd, i_mem_address[1:0]);
        mask_lanes_s  = lane_mask(width_s, i_mem_address[1:0]);
    end

    // Assemble load data; the high word only exists on the second half of a split access.
    always_comb begin
        load_pair_s = {32'h0000_0000, i_bus_rdata};
        if (state_r == ST_HI) begin
            load_pair_s = {i_bus_rdata, lo_rdata_r};
        end else begin
            load_pair_s = {32'h0000_0000, i_bus_rdata};
        end
        load_value_s = load_extract(load_pair_s, offset_r, width_r, signed_r);
    end

    assign o_stall = (i_tag != o_tag) && is_mem_s;

    // Access sequencer with registered writeback and bus outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r        <= ST_IDLE;
            offset_r       <= 2'd0;
            width_r        <= 3'd0;
            signed_r       <= 1'b0;
            write_r        <= 1'b0;
            split_r        <= 1'b0;
            hold_tag_r     <= 4'd0;
            hold_inst_rd_r <= 5'd0;
            hold_rd_r      <= 32'd0;
            lo_rdata_r     <= 32'd0;
            wdata_hi_r     <= 32'd0;
            wmask_hi_r     <= 4'd0;
            o_tag          <= 4'd0;
            o_inst_rd      <= 5'd0;
            o_rd           <= 32'd0;
            o_fault        <= 1'b0;
            o_bus_request  <= 1'b0;
            o_bus_rw       <= 1'b0;
            o_bus_address  <= 32'd0;
            o_bus_wdata    <= 32'd0;
            o_bus_wmask    <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !is_mem_s) begin
                        o_tag     <= i_tag;
                        o_inst_rd <= i_inst_rd;
                        o_rd      <= i_rd;
                    end else if (accept_s) begin
                        hold_tag_r    <= i_tag;
                        offset_r      <= i_mem_address[1:0];
                        width_r       <= width_s;
                        signed_r      <= i_mem_signed;
                        write_r       <= i_mem_write;
                        o_bus_rw      <= i_mem_write;
                        o_bus_address <= {i_mem_address[31:2], 2'b00};
                        o_bus_wdata   <= store_lanes_s[31:0];
                        o_bus_wmask   <= mask_lanes_s[3:0];
                        wdata_hi_r    <= store_lanes_s[63:32];
                        wmask_hi_r    <= mask_lanes_s[7:4];
                        hold_rd_r     <= 32'd0;
`ifdef CPU_MEMORY_MISALIGNED_EN
                        split_r        <= misaligned_s;
                        hold_inst_rd_r <= i_mem_write ? 5'd0 : i_inst_rd;
                        o_bus_request  <= 1'b1;
                        state_r        <= ST_LO;
`else
                        // A misaligned access never reaches the bus and retires as a no-op.
                        split_r        <= 1'b0;
                        hold_inst_rd_r <= (i_mem_write || misaligned_s) ? 5'd0 : i_inst_rd;
                        o_bus_request  <= !misaligned_s;
                        o_fault        <= o_fault || misaligned_s;
                        state_r        <= misaligned_s ? ST_RETIRE : ST_LO;
`endif
                    end
                end
                ST_LO: begin
                    if (i_bus_ready && split_r) begin
                        lo_rdata_r    <= i_bus_rdata;
                        o_bus_address <= o_bus_address + 32'd4;
                        o_bus_wdata   <= wdata_hi_r;
                        o_bus_wmask   <= wmask_hi_r;
                        state_r       <= ST_HI;
                    end else if (i_bus_ready) begin
                        o_bus_request <= 1'b0;
                        hold_rd_r     <= write_r ? 32'd0 : load_value_s;
                        state_r       <= ST_RETIRE;
                    end
                end
                ST_HI: begin
                    if (i_bus_ready) begin
                        o_bus_request <= 1'b0;
                        hold_rd_r     <= write_r ? 32'd0 : load_value_s;
                        state_r       <= ST_RETIRE;
                    end
                end
                ST_RETIRE: begin
                    if (!i_stall) begin
                        o_tag     <= hold_tag_r;
                        o_inst_rd <= hold_inst_rd_r;
                        o_rd      <= hold_rd_r;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    o_bus_request <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory: expected writebacks are queued at issue and popped when the tag retires.
module tb_cpu_memory;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_stall;
    logic [3:0]  i_tag;
    logic [4:0]  i_inst_rd;
    logic [31:0] i_rd;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_mem_width;
    logic        i_mem_signed;
    logic [31:0] i_mem_address;
    logic [3:0]  o_tag;
    logic [4:0]  o_inst_rd;
    logic [31:0] o_rd;
    logic        o_stall;
    logic        o_fault;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ready;

    cpu_memory dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall), .i_tag(i_tag),
        .i_inst_rd(i_inst_rd), .i_rd(i_rd), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_width(i_mem_width), .i_mem_signed(i_mem_signed), .i_mem_address(i_mem_address),
        .o_tag(o_tag), .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_stall(o_stall), .o_fault(o_fault),
        .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
        .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask), .i_bus_rdata(i_bus_rdata),
        .i_bus_ready(i_bus_ready)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd_idx;
        logic [31:0] rd_val;
        bit          chk_rd;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc;
    logic [3:0] cur_tag;
    logic [3:0] prev_tag;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clock);
    endtask

    task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] width, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd_idx,
                         input logic [4:0] exp_idx, input logic [31:0] exp_rd);
        exp_t e;
        cur_tag       = cur_tag + 4'd1;
        i_tag         = cur_tag;
        i_mem_read    = rd_en;
        i_mem_write   = wr_en;
        i_mem_width   = width;
        i_mem_signed  = sgn;
        i_mem_address = addr;
        i_rd          = data;
        i_inst_rd     = rd_idx;
        e.tag    = cur_tag;
        e.rd_idx = exp_idx;
        e.rd_val = exp_rd;
        e.chk_rd = !wr_en;
        sb.push_back(e);
        #1;
    endtask

    task automatic serve(input int delay, input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic exp_rw, input logic [31:0] exp_wdata, input logic [3:0] exp_wmask);
        for (int k = 0; k < delay; k++) begin
            step();
            check("bus_request", 32'(o_bus_request), 32'd1);
            check("bus_address", o_bus_address, exp_addr);
            check("bus_rw", 32'(o_bus_rw), 32'(exp_rw));
            check("stall_busy", 32'(o_stall), 32'd1);
            if (exp_rw) begin
                check("bus_wdata", o_bus_wdata, exp_wdata);
                check("bus_wmask", 32'(o_bus_wmask), 32'(exp_wmask));
            end
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = rdata;
        step();
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'd0;
    endtask

    task automatic wait_retire(input int bound, output int cycles);
        exp_t e;
        e = sb.pop_front();
        cycles = 0;
        while (cycles < bound && o_tag !== e.tag) begin
            step();
            cycles++;
        end
        check("retire_tag", 32'(o_tag), 32'(e.tag));
        check("retire_rd_idx", 32'(o_inst_rd), 32'(e.rd_idx));
        if (e.chk_rd) begin
            check("retire_rd", o_rd, e.rd_val);
        end
        check("stall_after_retire", 32'(o_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_stall = 1'b0; i_tag = 4'd0; i_inst_rd = 5'd0; i_rd = 32'd0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_width = 3'd4; i_mem_signed = 1'b0;
        i_mem_address = 32'd0; i_bus_rdata = 32'd0; i_bus_ready = 1'b0; cur_tag = 4'd0;
        step(); step();
        check("reset_tag", 32'(o_tag), 32'd0);
        check("reset_rd", o_rd, 32'd0);
        check("reset_request", 32'(o_bus_request), 32'd0);
        check("reset_fault", 32'(o_fault), 32'd0);
        check("reset_stall", 32'(o_stall), 32'd0);
        i_reset = 1'b0;

        // non-memory pass-through, latency 1
        issue(1'b0, 1'b0, 3'd4, 1'b0, 32'd0, 32'h55, 5'd5, 5'd5, 32'h55);
        check("nonmem_stall", 32'(o_stall), 32'd0);
        wait_retire(4, cyc);
        check("nonmem_latency", 32'(cyc), 32'd1);

        // LB signed at byte 3, slow slave
        issue(1'b1, 1'b0, 3'd1, 1'b1, 32'h1003, 32'd0, 5'd3, 5'd3, 32'hFFFF_FF80);
        check("lb_stall_issue", 32'(o_stall), 32'd1);
        serve(5, 32'h8011_2233, 32'h1000, 1'b0, 32'd0, 4'd0);
        check("lb_request_drop", 32'(o_bus_request), 32'd0);
        wait_retire(4, cyc);
        check("lb_retire_latency", 32'(cyc), 32'd1);

        issue(1'b1, 1'b0, 3'd1, 1'b0, 32'h1003, 32'd0, 5'd4, 5'd4, 32'h0000_0080);
        serve(2, 32'h8011_2233, 32'h1000, 1'b0, 32'd0, 4'd0);
        wait_retire(4, cyc);

        // stores: half, byte, word, and read+write treated as store
        issue(1'b0, 1'b1, 3'd2, 1'b0, 32'h1002, 32'h0000_1234, 5'd7, 5'd0, 32'd0);
        serve(1, 32'd0, 32'h1000, 1'b1, 32'h1234_0000, 4'b1100);
        wait_retire(4, cyc);
        issue(1'b0, 1'b1, 3'd1, 1'b0, 32'h1001, 32'h0000_00AB, 5'd8, 5'd0, 32'd0);
        serve(1, 32'd0, 32'h1000, 1'b1, 32'h0000_AB00, 4'b0010);
        wait_retire(4, cyc);
        issue(1'b0, 1'b1, 3'd4, 1'b0, 32'h2000, 32'hDEAD_BEEF, 5'd9, 5'd0, 32'd0);
        serve(1, 32'd0, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'b1111);
        wait_retire(4, cyc);
        issue(1'b1, 1'b1, 3'd4, 1'b0, 32'h2004, 32'h1122_3344, 5'd9, 5'd0, 32'd0);
        serve(1, 32'd0, 32'h2004, 1'b1, 32'h1122_3344, 4'b1111);
        wait_retire(4, cyc);

        // LH signed upper half, and an odd width read as a word
        issue(1'b1, 1'b0, 3'd2, 1'b1, 32'h1002, 32'd0, 5'd9, 5'd9, 32'hFFFF_8001);
        serve(1, 32'h8001_7777, 32'h1000, 1'b0, 32'd0, 4'd0);
        wait_retire(4, cyc);
        issue(1'b1, 1'b0, 3'd3, 1'b0, 32'h2000, 32'd0, 5'd10, 5'd10, 32'hCAFE_F00D);
        serve(1, 32'hCAFE_F00D, 32'h2000, 1'b0, 32'd0, 4'd0);
        wait_retire(4, cyc);

`ifdef CPU_MEMORY_MISALIGNED_EN
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h1001, 32'd0, 5'd11, 5'd11, 32'h5544_3322);
        serve(1, 32'h4433_2211, 32'h1000, 1'b0, 32'd0, 4'd0);
        serve(1, 32'h8877_6655, 32'h1004, 1'b0, 32'd0, 4'd0);
        wait_retire(4, cyc);
        issue(1'b1, 1'b0, 3'd2, 1'b1, 32'hFFFF_FFFF, 32'd0, 5'd12, 5'd12, 32'hFFFF_CDAB);
        serve(1, 32'hAB00_0000, 32'hFFFF_FFFC, 1'b0, 32'd0, 4'd0);
        serve(1, 32'h0000_00CD, 32'h0000_0000, 1'b0, 32'd0, 4'd0);
        wait_retire(4, cyc);
        issue(1'b0, 1'b1, 3'd4, 1'b0, 32'h2002, 32'hAABB_CCDD, 5'd13, 5'd0, 32'd0);
        serve(1, 32'd0, 32'h2000, 1'b1, 32'hCCDD_0000, 4'b1100);
        serve(1, 32'd0, 32'h2004, 1'b1, 32'h0000_AABB, 4'b0011);
        wait_retire(4, cyc);
        check("no_fault_split", 32'(o_fault), 32'd0);
`else
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h1001, 32'd0, 5'd11, 5'd0, 32'd0);
        step();
        check("misaligned_no_request", 32'(o_bus_request), 32'd0);
        check("misaligned_fault", 32'(o_fault), 32'd1);
        wait_retire(4, cyc);
        check("misaligned_fault_sticky", 32'(o_fault), 32'd1);
`endif

        // writeback stall holds the retire
        prev_tag = cur_tag;
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h2004, 32'd0, 5'd12, 5'd12, 32'h1234_5678);
        step();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h1234_5678;
        i_stall = 1'b1;
        step();
        i_bus_ready = 1'b0;
        i_bus_rdata = 32'd0;
        for (int k = 0; k < 3; k++) begin
            check("stall_hold_tag", 32'(o_tag), 32'(prev_tag));
            step();
        end
        check("stall_hold_tag_end", 32'(o_tag), 32'(prev_tag));
        i_stall = 1'b0;
        wait_retire(4, cyc);
        check("stall_release_latency", 32'(cyc), 32'd1);

        // reset while a request is outstanding
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h3000, 32'd0, 5'd13, 5'd13, 32'd0);
        step();
        check("pre_reset_request", 32'(o_bus_request), 32'd1);
        i_reset = 1'b1;
        #1;
        check("async_reset_request", 32'(o_bus_request), 32'd0);
        check("async_reset_tag", 32'(o_tag), 32'd0);
        check("async_reset_rd", o_rd, 32'd0);
        check("async_reset_address", o_bus_address, 32'd0);
        check("async_reset_fault", 32'(o_fault), 32'd0);
        sb.delete();
        step();
        i_reset = 1'b0;
        cur_tag = 4'd0;
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h3000, 32'd0, 5'd14, 5'd14, 32'h0BAD_F00D);
        serve(1, 32'h0BAD_F00D, 32'h3000, 1'b0, 32'd0, 4'd0);
        wait_retire(4, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
